audio_channel_mixer: RTL
========================

// Module: audio_channel_mixer
// PURPOSE
//  N-channel stereo mixer in the clk_sys domain, placed ahead of the audio FIFO/filter chain.
//  Per-channel gain/enable, signed/unsigned input conversion, L/R crossfeed, pause soft-mute
//  ramp and output saturation; one output frame per sample strobe, time-multiplexed MAC.
// PARAMETERS
//  DW         16  input sample width per channel (8..16)
//  OW         16  output sample width (OW <= DW+1)
//  CHANNELS    4  number of stereo input channels (1..8)
//  GAIN_W      8  unsigned per-channel gain width; UNITY = 1<<(GAIN_W-1)
//  RAMP_STEP   1  mute-gain change per accepted frame
// PORTS
//  clk_sys     in   1              core system clock
//  reset       in   1              synchronous, active-high reset
//  sample_stb  in   1              one-cycle pulse: new frame on ch_* inputs
//  ch_l, ch_r  in   CHANNELS*DW    packed samples, channel 0 in LSBs
//  ch_signed   in   CHANNELS       1 = two's complement, 0 = offset binary
//  ch_gain     in   CHANNELS*GAIN_W per-channel gain, UNITY = 0 dB
//  ch_en       in   CHANNELS       0 = channel contributes 0
//  mix         in   2              0 none | 1 25% | 2 50% | 3 100% (mono) crossfeed
//  pause_core  in   1              ramp master gain to 0 while high
//  out_l,out_r out  OW             mixed signed output, held while out_valid
//  out_valid   out  1              frame ready; held until out_ready
//  out_ready   in   1              consumer accepts when out_valid & out_ready
//  busy        out  1              high in ACCUM..SAT
//  overrun     out  1              one-cycle pulse: strobe dropped
// BEHAVIOUR
//  - Reset: out_l/out_r=0, out_valid=0, busy=0, overrun=0, state IDLE, mute_gain=UNITY, acc=0.
//  - FSM IDLE->ACCUM->MIX->MASTER->SAT->HOLD->IDLE. sample_stb in IDLE: snapshot all ch_*/mix,
//    update mute_gain (pause: -RAMP_STEP floor 0; else +RAMP_STEP cap UNITY); frame uses new value.
//  - ACCUM: CHANNELS cycles, channel k on cycle k; offset-binary inputs get MSB inverted;
//    acc += sample*gain (signed); ACC_W = DW+GAIN_W+clog2(CHANNELS)+1, no internal overflow.
//  - MIX (arith. shift, floor): 0 L'=L; 1 L'=(7L+R)>>3; 2 L'=(3L+R)>>2; 3 L'=(L+R)>>1; R symmetric.
//  - MASTER: x = (x*mute_gain)>>(GAIN_W-1), then >>(GAIN_W-1) for channel unity scaling.
//  - SAT: clamp to [-2^(OW-1), 2^(OW-1)-1], register outputs, out_valid=1 -> HOLD.
//  - Latency: out_valid high exactly CHANNELS+3 cycles after the strobe cycle.
//  - HOLD: out_* stable; out_valid&out_ready -> out_valid=0, IDLE same edge; strobe on that
//    handshake edge is dropped (accept only in IDLE).
//  - sample_stb in any state but IDLE: frame dropped, overrun=1 next cycle, outputs untouched.
//  - reset mid-frame: aborts; next cycle all outputs at reset values, accumulator cleared.
//  - mute_gain=0: output exactly 0; all ch_en=0: output 0 (unsigned zero-points excluded).
// CONFIGURATION
//  AUDIO_MIXER_CLIP_EN defined: adds ports clip_clr(in,1), clip_l/clip_r(out,1 sticky),
//   clip_count(out,16, saturating at FFFF); increments once per frame if either side clamped;
//   clip_clr or reset clears all; clip_clr wins over a same-cycle clip event.
//  Undefined: those ports and logic absent; datapath identical.
// STRUCTURE
//  Package audio_mixer_pkg: mix_mode_e, mixer_state_e, UNITY_GAIN function of GAIN_W,
//   function sat_clamp(value, OW), function to_signed(sample, is_signed).
//  Sub-module audio_mix_mac: one multiply-accumulate lane (used twice, L and R) with
//   clear/enable; FSM, crossfeed, master gain and saturation stay in top.
// TESTING (CHANNELS=4, DW=OW=16, GAIN_W=8)
//  1 ch0 L=0x1000 gain 0x80, others en=0, strobe -> out_l=0x1000 with out_valid at strobe+7.
//  2 ch0 ch_signed=0, L=0xC000 gain 0x80 -> out_l=0x4000; L=0x8000 -> 0x0000.
//  3 all 4 ch L=0x7000 gain 0x80 -> out_l=0x7FFF; all 0x9000 -> 0x8000; clip_count += 1 each.
//  4 ch0 L=0x2000 R=0: mix=3 -> out_l=out_r=0x1000; mix=1 -> out_l=0x1C00, out_r=0x0400.
//  5 L=0x4000 unity, pause_core=1: frames 0x3F80,0x3F00,...; 128th frame 0x0000 and stays;
//    pause_core=0 -> 0x0080, 0x0100, ... back to 0x4000.
//  6 out_ready=0, second strobe -> overrun pulse, out_* unchanged; reset in ACCUM -> next cycle
//    out_valid=0, busy=0, out_l=0, following frame correct.

Source files
------------

// File: rtl/audio_mixer_pkg.sv
// Shared types and helpers for the audio channel mixer: crossfeed modes, FSM
// states, unity-gain derivation, output clamping and input-format conversion.
package audio_mixer_pkg;

  typedef enum logic [1:0] {
    MIX_NONE = 2'd0,
    MIX_25   = 2'd1,
    MIX_50   = 2'd2,
    MIX_MONO = 2'd3
  } mix_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_MIX    = 3'd2,
    ST_MASTER = 3'd3,
    ST_SAT    = 3'd4,
    ST_HOLD   = 3'd5
  } mixer_state_e;

  // 0 dB point of an unsigned gain word of gain_w bits
  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Clamp a wide signed value into the two's-complement range of ow bits
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Offset-binary samples become two's complement by flipping the MSB of the
  // width-bit field; two's-complement samples pass through untouched.
  function automatic logic [31:0] to_signed(input logic [31:0] sample,
                                            input int width,
                                            input logic is_signed);
    if (is_signed) return sample;
    return sample ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/audio_mix_mac.sv
// One multiply-accumulate lane of the mixer: acc += sample * gain, with a
// synchronous clear that takes priority over accumulation.
module audio_mix_mac #(
  parameter int DW     = 16,
  parameter int GAIN_W = 8,
  parameter int ACC_W  = 27
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DW-1:0]     sample,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [DW+GAIN_W:0] prod;

  // Gain is unsigned, so zero-extend it before the signed multiply
  assign prod = sample * $signed({1'b0, gain});

  // Accumulate one channel product per enabled cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/audio_channel_mixer.sv
// N-channel stereo mixer: per-channel gain/enable, offset-binary conversion,
// L/R crossfeed, pause soft-mute ramp and output saturation, one frame per
// sample strobe using a time-multiplexed MAC per side.
// Optional feature macro: AUDIO_MIXER_CLIP_EN adds sticky clip flags and a
// saturating clip counter; without it those ports do not exist.
module audio_channel_mixer
  import audio_mixer_pkg::*;
#(
  parameter int DW        = 16,
  parameter int OW        = 16,
  parameter int CHANNELS  = 4,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         sample_stb,
  input  logic [CHANNELS*DW-1:0]       ch_l,
  input  logic [CHANNELS*DW-1:0]       ch_r,
  input  logic [CHANNELS-1:0]          ch_signed,
  input  logic [CHANNELS*GAIN_W-1:0]   ch_gain,
  input  logic [CHANNELS-1:0]          ch_en,
  input  logic [1:0]                   mix,
  input  logic                         pause_core,
  output logic signed [OW-1:0]         out_l,
  output logic signed [OW-1:0]         out_r,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         overrun
`ifdef AUDIO_MIXER_CLIP_EN
  ,
  input  logic                         clip_clr,
  output logic                         clip_l,
  output logic                         clip_r,
  output logic [15:0]                  clip_count
`endif
);

  localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = DW + GAIN_W + $clog2(CHANNELS) + 1;
  localparam int MW    = ACC_W + 3;
  localparam int PW    = ACC_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] UNITY_G = GAIN_W'(unity_gain(GAIN_W));
  localparam logic [GAIN_W-1:0] STEP_G  = GAIN_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0]  LAST_CH = CNT_W'(CHANNELS - 1);

  mixer_state_e              state;
  logic [CNT_W-1:0]          ch_idx;
  logic [GAIN_W-1:0]         mute_gain;
  logic [GAIN_W-1:0]         next_mute;
  logic                      accept;

  logic [CHANNELS*DW-1:0]     ch_l_p0;
  logic [CHANNELS*DW-1:0]     ch_r_p0;
  logic [CHANNELS-1:0]        sgn_p0;
  logic [CHANNELS*GAIN_W-1:0] gain_p0;
  logic [CHANNELS-1:0]        en_p0;
  mix_mode_e                  mix_p0;

  logic [DW-1:0]             raw_l;
  logic [DW-1:0]             raw_r;
  logic [GAIN_W-1:0]         lane_gain;
  logic                      lane_sgn;
  logic                      lane_en;
  logic signed [DW-1:0]      samp_l;
  logic signed [DW-1:0]      samp_r;
  logic signed [ACC_W-1:0]   acc_l;
  logic signed [ACC_W-1:0]   acc_r;

  logic signed [MW-1:0]      lw;
  logic signed [MW-1:0]      rw;
  logic signed [MW-1:0]      mix_l_w;
  logic signed [MW-1:0]      mix_r_w;
  logic signed [ACC_W-1:0]   mix_l_p1;
  logic signed [ACC_W-1:0]   mix_r_p1;

  logic signed [PW-1:0]      gain_l_w;
  logic signed [PW-1:0]      gain_r_w;
  logic signed [ACC_W-1:0]   master_l_p2;
  logic signed [ACC_W-1:0]   master_r_p2;

  logic signed [OW-1:0]      sat_l;
  logic signed [OW-1:0]      sat_r;

  assign accept = (state == ST_IDLE) && sample_stb;

  // Soft-mute ramp target for the frame being accepted
  always_comb begin
    next_mute = mute_gain;
    if (pause_core) begin
      next_mute = (mute_gain > STEP_G) ? (mute_gain - STEP_G) : '0;
    end else begin
      next_mute = (mute_gain < (UNITY_G - STEP_G)) ? (mute_gain + STEP_G) : UNITY_G;
    end
  end

  // ---- stage p0: channel lane selection from the frame snapshot ----
  assign raw_l     = ch_l_p0[int'(ch_idx)*DW +: DW];
  assign raw_r     = ch_r_p0[int'(ch_idx)*DW +: DW];
  assign lane_gain = gain_p0[int'(ch_idx)*GAIN_W +: GAIN_W];
  assign lane_sgn  = sgn_p0[ch_idx];
  assign lane_en   = en_p0[ch_idx];
  assign samp_l    = lane_en ? DW'(to_signed(32'(raw_l), DW, lane_sgn)) : '0;
  assign samp_r    = lane_en ? DW'(to_signed(32'(raw_r), DW, lane_sgn)) : '0;

  audio_mix_mac #(.DW(DW), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_l (
    .clk    (clk_sys),
    .clr    (reset || accept),
    .en     (state == ST_ACCUM),
    .sample (samp_l),
    .gain   (lane_gain),
    .acc    (acc_l)
  );

  audio_mix_mac #(.DW(DW), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_r (
    .clk    (clk_sys),
    .clr    (reset || accept),
    .en     (state == ST_ACCUM),
    .sample (samp_r),
    .gain   (lane_gain),
    .acc    (acc_r)
  );

  // ---- stage p1: L/R crossfeed, floor via arithmetic shift ----
  assign lw = MW'(acc_l);
  assign rw = MW'(acc_r);

  // Weighted crossfeed; weights sum to one so the result fits the accumulator width
  always_comb begin
    mix_l_w = lw;
    mix_r_w = rw;
    case (mix_p0)
      MIX_NONE: begin
        mix_l_w = lw;
        mix_r_w = rw;
      end
      MIX_25: begin
        mix_l_w = ((lw <<< 3) - lw + rw) >>> 3;
        mix_r_w = ((rw <<< 3) - rw + lw) >>> 3;
      end
      MIX_50: begin
        mix_l_w = ((lw <<< 1) + lw + rw) >>> 2;
        mix_r_w = ((rw <<< 1) + rw + lw) >>> 2;
      end
      MIX_MONO: begin
        mix_l_w = (lw + rw) >>> 1;
        mix_r_w = (lw + rw) >>> 1;
      end
      default: begin
        mix_l_w = lw;
        mix_r_w = rw;
      end
    endcase
  end

  // ---- stage p2: master mute gain, then remove the channel unity scaling ----
  assign gain_l_w = PW'(mix_l_p1) * $signed({1'b0, mute_gain});
  assign gain_r_w = PW'(mix_r_p1) * $signed({1'b0, mute_gain});

  // ---- output stage: saturation to OW bits ----
  assign sat_l = OW'(sat_clamp(64'(master_l_p2), OW));
  assign sat_r = OW'(sat_clamp(64'(master_r_p2), OW));

  // Datapath registers: frame snapshot, crossfeed and master-gain results
  always_ff @(posedge clk_sys) begin
    if (accept) begin
      ch_l_p0 <= ch_l;
      ch_r_p0 <= ch_r;
      sgn_p0  <= ch_signed;
      gain_p0 <= ch_gain;
      en_p0   <= ch_en;
      mix_p0  <= mix_mode_e'(mix);
    end
    if (state == ST_MIX) begin
      mix_l_p1 <= ACC_W'(mix_l_w);
      mix_r_p1 <= ACC_W'(mix_r_w);
    end
    if (state == ST_MASTER) begin
      master_l_p2 <= ACC_W'((gain_l_w >>> (GAIN_W - 1)) >>> (GAIN_W - 1));
      master_r_p2 <= ACC_W'((gain_r_w >>> (GAIN_W - 1)) >>> (GAIN_W - 1));
    end
  end

  // Frame sequencer with registered outputs, overrun detection and mute ramp
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      ch_idx    <= '0;
      mute_gain <= UNITY_G;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= sample_stb && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (sample_stb) begin
            state     <= ST_ACCUM;
            ch_idx    <= '0;
            busy      <= 1'b1;
            mute_gain <= next_mute;
          end
        end
        ST_ACCUM: begin
          if (ch_idx == LAST_CH) begin
            state <= ST_MIX;
          end else begin
            ch_idx <= ch_idx + CNT_W'(1);
          end
        end
        ST_MIX:    state <= ST_MASTER;
        ST_MASTER: state <= ST_SAT;
        ST_SAT: begin
          out_l     <= sat_l;
          out_r     <= sat_r;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AUDIO_MIXER_CLIP_EN
  logic clip_l_evt;
  logic clip_r_evt;

  assign clip_l_evt = (64'(sat_l) != 64'(master_l_p2));
  assign clip_r_evt = (64'(sat_r) != 64'(master_r_p2));

  // Sticky clip flags and per-frame clip counter; clear beats a same-cycle clip
  always_ff @(posedge clk_sys) begin
    if (reset || clip_clr) begin
      clip_l     <= 1'b0;
      clip_r     <= 1'b0;
      clip_count <= '0;
    end else if ((state == ST_SAT) && (clip_l_evt || clip_r_evt)) begin
      clip_l <= clip_l | clip_l_evt;
      clip_r <= clip_r | clip_r_evt;
      if (clip_count != 16'hFFFF) begin
        clip_count <= clip_count + 16'd1;
      end
    end
  end
`endif

endmodule
